// File: rtl/masked_sbox_scheduler_pkg.sv
// Shared types and constants for the masked S-box scheduler slice.
//   bv8_t        : one Boolean share of a byte
//   sched_tag_t  : default-width opaque requester tag
//   sbox_latency : pipeline depth of the HPC1 Canright S-box for a given
//                  share count (default for the scheduler's LATENCY)
package masked_sbox_scheduler_pkg;

    typedef logic [7:0] bv8_t;

    localparam int SCHED_TAG_W = 4;
    typedef logic [SCHED_TAG_W-1:0] sched_tag_t;

    // Masked HPC1 gadgets need register stages after the input basis change,
    // the GF(2^4) inverter and the output map; an unmasked S-box needs one.
    function automatic int sbox_latency(input int num_shares);
        return (num_shares >= 2) ? 3 : 1;
    endfunction

endpackage

// File: rtl/masked_sbox_scheduler_rsp_fifo.sv
// masked_rsp_fifo: per-requester response buffer holding {tag, shared byte}.
// Shares are only stored and muxed here, never combined.
// Ports:
//   in_clock, in_reset        clock, synchronous active-high reset
//   in_wr_en, in_wr_data      write one payload (never issued when full)
//   in_rd_en                  pop the head when out_valid is high
//   out_valid, out_rd_data    head-of-queue payload (zero when empty)
// Write and pop may happen in the same cycle at any occupancy; a write into
// an empty FIFO becomes visible one cycle later (no bypass).
module masked_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_wr_en,
    input  logic [WIDTH-1:0] in_wr_data,
    input  logic             in_rd_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_rd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid   = (r_count != '0);
    assign w_pop       = in_rd_en && out_valid;
    // Gate the head so stale share material never appears on the port.
    assign out_rd_data = out_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (in_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({in_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_wr_en) r_mem[r_wr_ptr] <= in_wr_data;
    end

endmodule

// File: rtl/masked_sbox_scheduler.sv
// masked_sbox_scheduler: shares one fixed-latency, non-stalling masked S-box
// between NUM_REQ requesters. Round-robin arbitration, a LATENCY-deep
// valid/owner/tag tracker, and one response FIFO per requester.
// Ports:
//   in_clock, in_reset            clock, synchronous active-high reset
//   in_req_valid / out_req_ready  request handshake per requester
//   in_req_data, in_req_tag       shared byte and tag per requester
//   out_sbox_in / in_sbox_out     S-box operand (zero when idle) / result
//   in_rand_valid, out_rand_req   fresh randomness present / needed
//   out_rand_error                sticky: randomness missing while busy
//   out_rsp_valid / in_rsp_ready  response handshake per requester
//   out_rsp_data, out_rsp_tag     FIFO head per requester
// Handshakes: a request transfers in the cycle where in_req_valid[i] and
// out_req_ready[i] are both high; out_req_ready is a combinational one-hot
// grant and may be high only while in_req_valid[i] is high. A response
// transfers where out_rsp_valid[i] and in_rsp_ready[i] are both high;
// out_rsp_valid/data/tag stay stable until that transfer.
module masked_sbox_scheduler
    import masked_sbox_scheduler_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int NUM_REQ    = 2,
    parameter int LATENCY    = sbox_latency(NUM_SHARES),
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = SCHED_TAG_W
) (
    input  logic                              in_clock,
    input  logic                              in_reset,
    input  logic [NUM_REQ-1:0]                in_req_valid,
    output logic [NUM_REQ-1:0]                out_req_ready,
    input  logic [NUM_REQ*NUM_SHARES*8-1:0]   in_req_data,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]      in_req_tag,
    output logic [NUM_SHARES*8-1:0]           out_sbox_in,
    input  logic [NUM_SHARES*8-1:0]           in_sbox_out,
    input  logic                              in_rand_valid,
    output logic                              out_rand_req,
    output logic                              out_rand_error,
    output logic [NUM_REQ-1:0]                out_rsp_valid,
    input  logic [NUM_REQ-1:0]                in_rsp_ready,
    output logic [NUM_REQ*NUM_SHARES*8-1:0]   out_rsp_data,
    output logic [NUM_REQ*TAG_WIDTH-1:0]      out_rsp_tag
);

    localparam int SW    = NUM_SHARES * $bits(bv8_t);
    localparam int PW    = TAG_WIDTH + SW;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]     r_cnt      [NUM_REQ];
    logic [LATENCY-1:0]   r_sr_valid;
    logic [RR_W-1:0]      r_sr_owner [LATENCY];
    logic [TAG_WIDTH-1:0] r_sr_tag   [LATENCY];
    logic                 r_rand_error;

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_grant_any;
    logic [RR_W-1:0]      w_grant_idx;
    logic [TAG_WIDTH-1:0] w_req_tag;
    logic [NUM_REQ-1:0]   w_pop;
    logic [NUM_REQ-1:0]   w_fifo_wr;
    logic [NUM_REQ-1:0]   w_rsp_valid;
    logic [PW-1:0]        w_fifo_wdata;
    logic [PW-1:0]        w_rsp_payload [NUM_REQ];

    // cnt counts in-flight plus buffered bytes, so a requester can never
    // have more results coming than its FIFO can hold.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = in_req_valid[i] && (r_cnt[i] < CNT_W'(DEPTH));
        end
    end

    // Round-robin: first eligible requester at or after the pointer.
    // Nothing issues without fresh randomness or while reset is applied.
    always_comb begin : arbiter
        logic [RR_W:0]   w_idx_ext;
        logic [RR_W-1:0] w_cand;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_idx_ext   = '0;
        w_cand      = '0;
        if (in_rand_valid && !in_reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx_ext = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
                if (w_idx_ext >= (RR_W+1)'(NUM_REQ)) begin
                    w_idx_ext = w_idx_ext - (RR_W+1)'(NUM_REQ);
                end
                w_cand = w_idx_ext[RR_W-1:0];
                if (!w_grant_any && w_eligible[w_cand]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
        if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
    end

    always_comb begin
        out_sbox_in = '0;
        w_req_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                out_sbox_in = in_req_data[i*SW +: SW];
                w_req_tag   = in_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign out_req_ready = w_grant;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr <= (w_grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + RR_W'(1);
        end
    end

    // Tracker mirrors the S-box pipeline: stage LATENCY-1 holds the byte
    // whose result is on in_sbox_out this cycle.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_sr_valid <= '0;
        end else begin
            r_sr_valid[0] <= w_grant_any;
            for (int k = 1; k < LATENCY; k++) begin
                r_sr_valid[k] <= r_sr_valid[k-1];
            end
        end
    end

    // Owner/tag are qualified by r_sr_valid and need no reset.
    always_ff @(posedge in_clock) begin
        r_sr_owner[0] <= w_grant_idx;
        r_sr_tag[0]   <= w_req_tag;
        for (int k = 1; k < LATENCY; k++) begin
            r_sr_owner[k] <= r_sr_owner[k-1];
            r_sr_tag[k]   <= r_sr_tag[k-1];
        end
    end

    assign w_fifo_wdata = {r_sr_tag[LATENCY-1], in_sbox_out};
    assign w_pop        = w_rsp_valid & in_rsp_ready;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_fifo_wr[g] = r_sr_valid[LATENCY-1] && (r_sr_owner[LATENCY-1] == RR_W'(g));

        masked_rsp_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (PW)
        ) u_rsp_fifo (
            .in_clock    (in_clock),
            .in_reset    (in_reset),
            .in_wr_en    (w_fifo_wr[g]),
            .in_wr_data  (w_fifo_wdata),
            .in_rd_en    (in_rsp_ready[g]),
            .out_valid   (w_rsp_valid[g]),
            .out_rd_data (w_rsp_payload[g])
        );

        assign out_rsp_data[g*SW +: SW]              = w_rsp_payload[g][SW-1:0];
        assign out_rsp_tag[g*TAG_WIDTH +: TAG_WIDTH] = w_rsp_payload[g][PW-1:SW];
    end

    assign out_rsp_valid = w_rsp_valid;

    // Every gadget stage holding live data consumes fresh masks each cycle.
    assign out_rand_req = w_grant_any || (|r_sr_valid);

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_rand_error <= 1'b0;
        end else if (out_rand_req && !in_rand_valid) begin
            r_rand_error <= 1'b1;
        end
    end

    assign out_rand_error = r_rand_error;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
module tb_masked_sbox_scheduler;
  import masked_sbox_scheduler_pkg::*;

  localparam int NR  = 2;
  localparam int NS  = 2;
  localparam int LAT = 3;
  localparam int DEP = 4;
  localparam int TW  = 4;
  localparam int SW  = NS * 8;
  localparam int EW  = TW + 8;

  // ---------------- clock / reset / DUT ----------------
  logic              in_clock = 1'b0;
  logic              in_reset;
  logic [NR-1:0]     in_req_valid, out_req_ready, out_rsp_valid, in_rsp_ready;
  logic [NR*SW-1:0]  in_req_data, out_rsp_data;
  logic [NR*TW-1:0]  in_req_tag, out_rsp_tag;
  logic [SW-1:0]     out_sbox_in, in_sbox_out;
  logic              in_rand_valid, out_rand_req, out_rand_error;

  always #5 in_clock = ~in_clock;

  masked_sbox_scheduler #(
    .NUM_SHARES(NS), .NUM_REQ(NR), .LATENCY(LAT), .DEPTH(DEP), .TAG_WIDTH(TW)
  ) dut (
    .in_clock      (in_clock),
    .in_reset      (in_reset),
    .in_req_valid  (in_req_valid),
    .out_req_ready (out_req_ready),
    .in_req_data   (in_req_data),
    .in_req_tag    (in_req_tag),
    .out_sbox_in   (out_sbox_in),
    .in_sbox_out   (in_sbox_out),
    .in_rand_valid (in_rand_valid),
    .out_rand_req  (out_rand_req),
    .out_rand_error(out_rand_error),
    .out_rsp_valid (out_rsp_valid),
    .in_rsp_ready  (in_rsp_ready),
    .out_rsp_data  (out_rsp_data),
    .out_rsp_tag   (out_rsp_tag)
  );

  // ---------------- behavioural AES S-box ----------------
  function automatic bv8_t gmul(input bv8_t a_in, input bv8_t b);
    bv8_t p;
    bv8_t a;
    p = 8'h00;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic bv8_t sbox(input bv8_t x);
    bv8_t inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Masked S-box stand-in: LAT-cycle pipeline, result re-shared with a fresh mask.
  logic [SW-1:0] sb_pipe [LAT];

  function automatic logic [SW-1:0] remask(input logic [SW-1:0] x, input bv8_t m);
    bv8_t y;
    y = sbox(x[7:0] ^ x[15:8]);
    return {m, y ^ m};
  endfunction

  always @(posedge in_clock) begin
    sb_pipe[0] <= remask(out_sbox_in, 8'($urandom));
    for (int k = 1; k < LAT; k++) sb_pipe[k] <= sb_pipe[k-1];
  end

  assign in_sbox_out = sb_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_raw(input int r, input logic [EW-1:0] e);
    if (r == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic push_exp(input int r, input logic [SW-1:0] d, input logic [TW-1:0] t);
    push_raw(r, {t, sbox(d[7:0] ^ d[15:8])});
  endtask

  task automatic monitor();
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    for (int r = 0; r < NR; r++) begin
      if (!in_reset && out_rsp_valid[r] && in_rsp_ready[r]) begin
        got = {out_rsp_tag[r*TW +: TW], out_rsp_data[r*SW +: 8] ^ out_rsp_data[r*SW+8 +: 8]};
        if ((r == 0 && exp_q0.size() == 0) || (r == 1 && exp_q1.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp%0d_unexpected: got 0x%0h expected no response", r, got);
        end else begin
          e = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("rsp%0d_tag_data", r), 32'(got), 32'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge in_clock);
    monitor();
    @(posedge in_clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [SW-1:0] d, input logic [TW-1:0] t);
    in_req_valid[r]        = v;
    in_req_data[r*SW +: SW] = d;
    in_req_tag[r*TW +: TW]  = t;
  endtask

  task automatic do_reset();
    in_reset      = 1'b1;
    in_req_valid  = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    in_rsp_ready  = '0;
    in_rand_valid = 1'b1;
    tick();
    tick();
    in_reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic drain(input string name);
    int n;
    in_req_valid = '0;
    in_rsp_ready = '1;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    check({name, "_q0_empty"}, 32'(exp_q0.size()), 32'd0);
    check({name, "_q1_empty"}, 32'(exp_q1.size()), 32'd0);
    tick();
    check({name, "_rsp_idle"}, 32'(out_rsp_valid), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            req;
    bv8_t          s0;
    bv8_t          s1;
    logic [TW-1:0] tag;
    bv8_t          exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [SW-1:0] d;
    logic [TW-1:0] t;
    logic [SW-1:0] d2;
    logic [TW-1:0] t2;
    logic [NR-1:0] pat [6];

    vecs[0] = '{0, 8'h5A, 8'h00, 4'h3, 8'hBE};
    vecs[1] = '{1, 8'h00, 8'h00, 4'h7, 8'h63};
    vecs[2] = '{0, 8'h01, 8'h00, 4'h1, 8'h7C};
    vecs[3] = '{1, 8'h12, 8'h48, 4'hA, 8'hBE};
    vecs[4] = '{0, 8'h53, 8'h00, 4'hF, 8'hED};
    vecs[5] = '{1, 8'hFF, 8'hFF, 4'h0, 8'h63};
    vecs[6] = '{0, 8'hF0, 8'h0F, 4'h5, 8'h16};
    vecs[7] = '{1, 8'h10, 8'h00, 4'hC, 8'hCA};

    in_reset = 1'b1;
    in_req_valid = '0; in_req_data = '0; in_req_tag = '0;
    in_rsp_ready = '0; in_rand_valid = 1'b0;

    // Reset state
    do_reset();
    settle();
    check("rst_req_ready",  32'(out_req_ready),  32'd0);
    check("rst_rsp_valid",  32'(out_rsp_valid),  32'd0);
    check("rst_sbox_in",    32'(out_sbox_in),    32'd0);
    check("rst_rand_req",   32'(out_rand_req),   32'd0);
    check("rst_rand_error", 32'(out_rand_error), 32'd0);
    check("rst_rsp_data",   32'(out_rsp_data),   32'd0);

    // Table: single requests, latency LAT+1, recombined result and tag
    in_rsp_ready = '1;
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].req, 1'b1, {vecs[i].s1, vecs[i].s0}, vecs[i].tag);
      push_raw(vecs[i].req, {vecs[i].tag, vecs[i].exp});
      settle();
      check($sformatf("tbl%0d_ready", i), 32'(out_req_ready), 32'd1 << vecs[i].req);
      check($sformatf("tbl%0d_sbox_in", i), 32'(out_sbox_in), 32'({vecs[i].s1, vecs[i].s0}));
      tick();
      in_req_valid = '0;
      lat = 1;
      while (!out_rsp_valid[vecs[i].req] && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(LAT + 1));
      tick();
    end
    drain("tbl");

    // Round robin with both requesters always valid: 0,1,0,1,...
    do_reset();
    in_rsp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      d = 16'($urandom); t = 4'($urandom);
      d2 = 16'($urandom); t2 = 4'($urandom);
      set_req(0, 1'b1, d, t);
      set_req(1, 1'b1, d2, t2);
      if (c % 2 == 0) push_exp(0, d, t);
      else            push_exp(1, d2, t2);
      settle();
      check($sformatf("alt%0d_grant", c), 32'(out_req_ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    drain("alt");

    // Backpressure: requester 0 only, no pops -> exactly DEPTH grants
    do_reset();
    in_rsp_ready = '0;
    for (int c = 0; c < 8; c++) begin
      d = 16'($urandom); t = 4'($urandom);
      set_req(0, 1'b1, d, t);
      if (c < DEP) push_exp(0, d, t);
      settle();
      check($sformatf("bp%0d_grant", c), 32'(out_req_ready), (c < DEP) ? 32'd1 : 32'd0);
      tick();
    end
    // One pop -> exactly one new grant the next cycle
    in_rsp_ready[0] = 1'b1;
    set_req(0, 1'b1, 16'($urandom), 4'($urandom));
    settle();
    check("pop_cycle_grant", 32'(out_req_ready), 32'd0);
    tick();
    in_rsp_ready[0] = 1'b0;
    d = 16'($urandom); t = 4'($urandom);
    set_req(0, 1'b1, d, t);
    push_exp(0, d, t);
    settle();
    check("after_pop_grant", 32'(out_req_ready), 32'd1);
    tick();
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, 16'($urandom), 4'($urandom));
      settle();
      check($sformatf("refull%0d_grant", c), 32'(out_req_ready), 32'd0);
      tick();
    end

    // Full (cnt=DEPTH) with pops enabled: grant+pop cycles keep cnt unchanged
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b01;
    pat[3] = 2'b01; pat[4] = 2'b01; pat[5] = 2'b00;
    in_rsp_ready[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      d = 16'($urandom); t = 4'($urandom);
      set_req(0, 1'b1, d, t);
      if (pat[c][0]) push_exp(0, d, t);
      settle();
      check($sformatf("gp%0d_grant", c), 32'(out_req_ready), 32'(pat[c]));
      tick();
    end
    drain("gp");

    // No randomness while idle: no grants, no error
    do_reset();
    in_rand_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, 16'($urandom), 4'($urandom));
      set_req(1, 1'b1, 16'($urandom), 4'($urandom));
      settle();
      check($sformatf("norand%0d_grant", c), 32'(out_req_ready), 32'd0);
      check($sformatf("norand%0d_rand_req", c), 32'(out_rand_req), 32'd0);
      check($sformatf("norand%0d_error", c), 32'(out_rand_error), 32'd0);
      tick();
    end

    // Randomness drops one cycle after a grant -> sticky error
    in_rand_valid = 1'b1;
    d = 16'($urandom); t = 4'($urandom);
    set_req(0, 1'b1, d, t);
    push_exp(0, d, t);
    settle();
    check("rerr_grant", 32'(out_req_ready), 32'd1);
    tick();
    in_req_valid = '0;
    in_rand_valid = 1'b0;
    settle();
    check("rerr_rand_req", 32'(out_rand_req), 32'd1);
    check("rerr_before", 32'(out_rand_error), 32'd0);
    tick();
    in_rand_valid = 1'b1;
    check("rerr_set", 32'(out_rand_error), 32'd1);
    for (int c = 0; c < 6; c++) tick();
    check("rerr_held", 32'(out_rand_error), 32'd1);
    drain("rerr");
    do_reset();
    settle();
    check("rerr_cleared", 32'(out_rand_error), 32'd0);

    // Reset two cycles after a grant discards in-flight bytes
    in_rsp_ready = '1;
    set_req(0, 1'b1, 16'($urandom), 4'($urandom));
    settle();
    check("mrst_grant0", 32'(out_req_ready), 32'd1);
    tick();
    settle();
    check("mrst_grant1", 32'(out_req_ready), 32'd1);
    tick();
    in_reset = 1'b1;
    settle();
    check("mrst_gate", 32'(out_req_ready), 32'd0);
    tick();
    in_reset = 1'b0;
    d = 16'($urandom); t = 4'($urandom);
    set_req(0, 1'b1, d, t);
    push_exp(0, d, t);
    settle();
    check("mrst_resume_grant", 32'(out_req_ready), 32'd1);
    check("mrst_rsp_valid", 32'(out_rsp_valid), 32'd0);
    check("mrst_error", 32'(out_rand_error), 32'd0);
    tick();
    in_req_valid = '0;
    for (int c = 0; c < LAT; c++) begin
      check($sformatf("mrst_no_rsp%0d", c), 32'(out_rsp_valid), 32'd0);
      tick();
    end
    check("mrst_new_rsp", 32'(out_rsp_valid), 32'd1);
    drain("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
